cim_weight_bank: RTL and testbench

//  Parametrised CIM weight storage bank: DEPTH entries of DATA_WIDTH bits each; LSB of each entry is metadata (data-line select).

---
 rtl/cim_weight_bank.sv | 140 ++++++++++++++
 tb/tb_cim_weight_bank.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_weight_bank.sv
// CIM weight storage bank: DEPTH words with metadata in bit 0, a burst-load FSM,
// a bulk-clear FSM and a registered 1-cycle read port with gated-zero output.
module cim_weight_bank #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cmd,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-2:0] rd_weight,
  output logic                  rd_meta,
  output logic                  rd_valid
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StLoad, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign wr_ready  = en && (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err_cmd   = err_q;
  assign rd_data   = rd_data_q;
  assign rd_weight = rd_data_q[DATA_WIDTH-1:1];
  assign rd_meta   = rd_data_q[0];
  assign rd_valid  = rd_valid_q;

  // In CLEAR, addr_q doubles as the sweep counter.
  assign mem_we    = en && (((state_q == StLoad) && wr_valid) || (state_q == StClear));
  assign mem_wdata = (state_q == StClear) ? '0 : wr_data;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_d = StClear;
            addr_d  = '0;
            err_d   = load_start;
          end else if (load_start) begin
            if (load_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StLoad;
              addr_d  = load_base;
              rem_d   = load_len;
            end
          end
        end
        StLoad: begin
          err_d = load_start || clear_start;
          if (wr_valid) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            if (rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        StClear: begin
          err_d  = load_start || clear_start;
          addr_d = addr_q + 1'b1;
          if (addr_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so an abort keeps written words.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (en && rd_en) begin
      rd_data_q  <= mem_q[rd_addr];
      rd_valid_q <= 1'b1;
    end else begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cim_weight_bank.sv
// Self-checking bench for cim_weight_bank: a reference memory model feeds a read scoreboard.
module tb_cim_weight_bank;

  localparam int DW = 9;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clear_start;
  logic          busy;
  logic          done;
  logic          err_cmd;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-2:0] rd_weight;
  logic          rd_meta;
  logic          rd_valid;

  cim_weight_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_start(clear_start), .busy(busy), .done(done), .err_cmd(err_cmd), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_weight(rd_weight), .rd_meta(rd_meta),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            total;
  int            bad;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] bdata [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read transaction: expectation queued at issue, popped when the word comes back.
  task automatic rd(input logic [AW-1:0] a, input string name);
    logic [DW-1:0] exp;
    sb.push_back(model[a]);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s rd_valid addr=%0d got=%b want=1", name, a, rd_valid);
    end
    exp = sb.pop_front();
    total++;
    if (rd_data !== exp) begin
      bad++;
      $display("FAIL %s rd_data addr=%0d got=%h want=%h", name, a, rd_data, exp);
    end
  endtask

  task automatic load_burst(input logic [AW-1:0] base, input int len, input bit gaps,
                            output int beats, output int dones);
    logic [AW-1:0] a;
    int            cyc;
    bit            acc;
    beats = 0;
    dones = 0;
    a = base;
    load_start = 1'b1;
    load_base  = base;
    load_len   = len[AW:0];
    step();
    load_start = 1'b0;
    cyc = 0;
    while (beats < len && cyc < 100) begin
      wr_valid = gaps ? (cyc % 3 != 1) : 1'b1;
      wr_data  = bdata[beats];
      acc = wr_valid && wr_ready;
      step();
      if (done === 1'b1) dones++;
      if (acc) begin
        model[a] = wr_data;
        a++;
        beats++;
      end
      cyc++;
    end
    wr_valid = 1'b0;
    repeat (3) begin
      step();
      if (done === 1'b1) dones++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    load_start = 1'b1;
    load_base  = '0;
    load_len   = 5'd3;
    rd_en      = 1'b1;
    rd_addr    = 4'd0;
    step();
    load_start = 1'b0;
    rd_en      = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, wr_ready, rd_valid, done, err_cmd} !== 5'b0 || rd_data !== '0) begin
      bad++;
      $display("FAIL reset_async busy/rdy/rv/done/err=%b%b%b%b%b rd_data=%h want all 0",
               busy, wr_ready, rd_valid, done, err_cmd, rd_data);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (done !== 1'b0 || err_cmd !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release done=%b err=%b busy=%b want 0", done, err_cmd, busy);
    end
    rd(4'd3, "reset_rd3");
  endtask

  task automatic test_load();
    logic [DW-2:0] ew [4];
    logic          em [4];
    int            beats;
    int            dones;
    ew = '{8'h80, 8'h51, 8'hFF, 8'h01};
    em = '{1'b1, 1'b0, 1'b1, 1'b1};
    bdata = '{9'h101, 9'h0A2, 9'h1FF, 9'h003};
    load_burst(4'd2, 4, 1'b1, beats, dones);
    total++;
    if (beats !== 4 || dones !== 1) begin
      bad++;
      $display("FAIL load_beats beats=%0d dones=%0d want 4/1", beats, dones);
    end
    for (int i = 0; i < 4; i++) begin
      rd(AW'(2 + i), "load_rd");
      total++;
      if (rd_weight !== ew[i] || rd_meta !== em[i]) begin
        bad++;
        $display("FAIL load_split i=%0d weight=%h meta=%b want %h/%b",
                 i, rd_weight, rd_meta, ew[i], em[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int beats;
    int dones;
    bdata = '{9'h011, 9'h022, 9'h033, 9'h044};
    load_burst(4'd14, 4, 1'b0, beats, dones);
    total++;
    if (beats !== 4 || dones !== 1) begin
      bad++;
      $display("FAIL wrap_beats beats=%0d dones=%0d want 4/1", beats, dones);
    end
    rd(4'd14, "wrap_rd14");
    rd(4'd15, "wrap_rd15");
    rd(4'd0, "wrap_rd0");
    rd(4'd1, "wrap_rd1");
    rd(4'd2, "wrap_rd2_untouched");
  endtask

  task automatic test_hazard();
    logic [DW-1:0] exp;
    load_start = 1'b1;
    load_base  = 4'd6;
    load_len   = 5'd4;
    step();
    load_start = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 9'h0AA;
    step();
    model[6] = 9'h0AA;
    wr_data = 9'h155;
    rd_en   = 1'b1;
    rd_addr = 4'd7;
    sb.push_back(model[7]);
    step();
    model[7] = 9'h155;
    rd_en = 1'b0;
    exp = sb.pop_front();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      bad++;
      $display("FAIL hazard_old rv=%b rd_data=%h want 1/%h", rd_valid, rd_data, exp);
    end
    en       = 1'b0;
    wr_data  = 9'h1EE;
    rd_en    = 1'b1;
    rd_addr  = 4'd6;
    repeat (3) begin
      step();
      total++;
      if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hazard_en0 rdy=%b rv=%b busy=%b want 0/0/1", wr_ready, rd_valid, busy);
      end
    end
    en      = 1'b1;
    rd_en   = 1'b0;
    wr_data = 9'h066;
    step();
    model[8] = 9'h066;
    wr_data = 9'h077;
    step();
    model[9] = 9'h077;
    wr_valid = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL hazard_done got=%b want=1", done);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hazard_idle done=%b busy=%b want 0/0", done, busy);
    end
    rd(4'd7, "hazard_new");
    rd(4'd6, "hazard_rd6");
    rd(4'd8, "hazard_rd8");
    rd(4'd9, "hazard_rd9");
    rd(4'd10, "hazard_rd10");
  endtask

  task automatic test_commands();
    int n;
    load_start  = 1'b1;
    clear_start = 1'b1;
    load_base   = 4'd0;
    load_len    = 5'd5;
    step();
    load_start  = 1'b0;
    clear_start = 1'b0;
    total++;
    if (busy !== 1'b1 || err_cmd !== 1'b1) begin
      bad++;
      $display("FAIL cmd_both busy=%b err=%b want 1/1", busy, err_cmd);
    end
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    n = 1;
    total++;
    if (busy !== 1'b1 || err_cmd !== 1'b1) begin
      bad++;
      $display("FAIL cmd_busy_start busy=%b err=%b want 1/1", busy, err_cmd);
    end
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n !== 16 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_len cycles=%0d busy=%b want 16/0", n, busy);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), "clear_rd");
    load_start = 1'b1;
    load_base  = 4'd3;
    load_len   = 5'd0;
    wr_valid   = 1'b1;
    wr_data    = 9'h1AB;
    step();
    load_start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL len0 done=%b busy=%b want 1/0", done, busy);
    end
    step();
    wr_valid = 1'b0;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL len0_pulse done=%b want 0", done);
    end
    rd(4'd3, "len0_nowrite");
  endtask

  task automatic test_abort();
    int dones;
    load_start = 1'b1;
    load_base  = 4'd10;
    load_len   = 5'd6;
    step();
    load_start = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 9'h0C1;
    step();
    model[10] = 9'h0C1;
    wr_data = 9'h0C2;
    step();
    model[11] = 9'h0C2;
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_async busy=%b rdy=%b done=%b want 0", busy, wr_ready, done);
    end
    step();
    rst_n = 1'b1;
    dones = 0;
    repeat (3) begin
      step();
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone dones=%0d busy=%b want 0/0", dones, busy);
    end
    for (int i = 10; i < 16; i++) rd(AW'(i), "abort_rd");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst_n       = 1'b0;
    en          = 1'b1;
    load_start  = 1'b0;
    load_base   = '0;
    load_len    = '0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    clear_start = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    test_reset();
    test_load();
    test_wrap();
    test_hazard();
    test_commands();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
